led_row_scanner: RTL and testbench
==================================

Name: led_row_scanner

Overview:
- Downstream consumer of the pattern-storage stage. Takes the registered 10x10 frame for the selected pattern and drives one LED layer by time-multiplexing its rows.
- Latches a whole frame into a shadow buffer at each frame boundary, so a pattern change mid-scan never tears the display.
- Per row: a blanking interval (anti-ghosting), then a dwell period with brightness-scaled column enable.
- Sits between pattern storage and the row/column driver pins.

Parameters:
- ROWS, 10, rows per layer; width of row_sel and number of frame rows.
- COLS, 10, columns per row; width of col_drive.
- ROW_CYCLES, 1000, clk cycles a row is selected (DRIVE dwell); must be >= 16.
- BLANK_CYCLES, 16, clk cycles with all rows and columns off before each row; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  1 = scan, 0 = display dark
- frame_in  input  ROWS*COLS  flattened frame; row r = frame_in[COLS*r+COLS-1 : COLS*r], bit COLS-1 = leftmost column
- brightness  input  4  duty level 0..15; sampled at frame load
- row_sel  output  ROWS  one-hot row select; row r = bit r
- col_drive  output  COLS  column drive for the selected row
- frame_start  output  1  one-cycle pulse on the cycle frame_in is latched
- row_idx  output  4  index of the row currently in BLANK/DRIVE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; row_sel=0, col_drive=0, frame_start=0, row_idx=0; shadow buffer=0; counters=0.
- All outputs are registered. Outputs reflect state one cycle after a transition.
- IDLE:
  - row_sel=0, col_drive=0.
  - enable=1 -> LOAD.
- LOAD (1 cycle):
  - shadow <= frame_in; bri <= brightness; row_idx <= 0; frame_start pulses for this one cycle.
  - Computes on_limit = ((bri+1)*ROW_CYCLES)>>4, using a width sufficient for 16*ROW_CYCLES.
  - -> BLANK.
- BLANK:
  - row_sel=0, col_drive=0; counter runs 0..BLANK_CYCLES-1.
  - At terminal count -> DRIVE with counter cleared.
- DRIVE:
  - row_sel = 1<<row_idx for all ROW_CYCLES cycles.
  - col_drive = shadow[row_idx] while counter < on_limit, else 0.
  - At counter = ROW_CYCLES-1:
    - row_idx < ROWS-1 -> row_idx+1, BLANK.
    - row_idx = ROWS-1 -> LOAD (wraps to row 0 with a fresh frame).
- Frame period = 1 + ROWS*(BLANK_CYCLES+ROW_CYCLES) cycles; frame_start pulses are exactly that far apart.
- enable=0 in any non-IDLE state -> IDLE on the next edge; outputs 0 the cycle after. Shadow is retained but reloaded on the next LOAD. Rows are never partially resumed.
- frame_in and brightness changes outside LOAD have no effect until the next LOAD.
- brightness=15 -> on_limit=ROW_CYCLES, i.e. full duty.
- brightness=0 -> on_limit = ROW_CYCLES>>4, minimum nonzero duty.
- At most one row_sel bit is high at any time. row_sel and col_drive are never nonzero during BLANK or IDLE.

Test Plan (ROW_CYCLES=16, BLANK_CYCLES=2):
- Reset then enable=1, frame_in all rows 10'b0110000110, brightness=15 -> frame_start pulses once. Two blank cycles follow, then row_sel=10'b0000000001 with col_drive=10'b0110000110 for 16 cycles. Next frame_start comes 181 cycles after the first.
- Frame with distinct rows (row r = 1<<r) -> each DRIVE window shows row_sel = col_drive = 1<<r for r=0..9 in order. A full BLANK precedes every row.
- brightness=0 -> col_drive nonzero for exactly 1 of 16 cycles per row. brightness=7 -> exactly 8 of 16. row_sel stays high for all 16 in both cases.
- Change frame_in and brightness during row 4 -> rows 4..9 keep the old data and duty. The new values appear from row 0 after the next frame_start.
- Deassert enable mid-DRIVE on row 6 -> outputs 0 within 2 cycles and stay 0. Reasserting enable -> frame_start, then the scan restarts at row 0.
- Assert rst mid-DRIVE -> all outputs 0 immediately, without waiting for a clock edge. After release with enable=1 -> LOAD and a normal scan.

Source files
------------

// File: rtl/led_row_scanner_if.sv
// Bus between the row scanner and its client: pattern and brightness in, row/column drive out.
interface led_row_scanner_if #(
  parameter int ROWS = 10,
  parameter int COLS = 10
);
  logic                   enable;
  logic [ROWS*COLS-1:0]   frame_in;
  logic [3:0]             brightness;
  logic [ROWS-1:0]        row_sel;
  logic [COLS-1:0]        col_drive;
  logic                   frame_start;
  logic [3:0]             row_idx;

  modport master (
    output enable, frame_in, brightness,
    input  row_sel, col_drive, frame_start, row_idx
  );

  modport slave (
    input  enable, frame_in, brightness,
    output row_sel, col_drive, frame_start, row_idx
  );
endinterface

// File: rtl/led_row_scanner.sv
// Time-multiplexed LED layer scanner: latch a frame, then per row blank and dwell with
// brightness-scaled column duty. Outputs are registered and trail the state by one cycle.
module led_row_scanner #(
  parameter int ROWS         = 10,
  parameter int COLS         = 10,
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  led_row_scanner_if.slave bus
);
  // One counter serves both BLANK and DRIVE; it must also hold on_limit (up to 16*ROW_CYCLES).
  localparam int CMAX = (16 * ROW_CYCLES > BLANK_CYCLES) ? 16 * ROW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_DRIVE} state_t;

  state_t                     r_state;
  logic [ROWS-1:0][COLS-1:0]  r_shadow;
  logic [CW-1:0]              r_cnt;
  logic [CW-1:0]              r_on_limit;
  logic [3:0]                 r_row;
  logic [ROWS-1:0]            r_row_sel;
  logic [COLS-1:0]            r_col_drive;
  logic                       r_frame_start;
  logic [3:0]                 r_row_idx;
  logic [CW-1:0]              w_on_limit;

  assign w_on_limit = ((CW'(bus.brightness) + CW'(1)) * CW'(ROW_CYCLES)) >> 4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_cnt         <= '0;
      r_on_limit    <= '0;
      r_row         <= '0;
      r_row_sel     <= '0;
      r_col_drive   <= '0;
      r_frame_start <= 1'b0;
      r_row_idx     <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_row_sel     <= '0;
      r_col_drive   <= '0;
      r_row_idx     <= r_row;
      if (!bus.enable) begin
        // Dropping enable abandons the row; a restart always begins with a fresh LOAD.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_row   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_LOAD;
            r_row   <= '0;
          end
          S_LOAD: begin
            r_shadow      <= bus.frame_in;
            r_on_limit    <= w_on_limit;
            r_frame_start <= 1'b1;
            r_cnt         <= '0;
            r_row         <= '0;
            r_state       <= S_BLANK;
          end
          S_BLANK: begin
            if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_DRIVE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DRIVE: begin
            r_row_sel <= ROWS'(1) << r_row;
            if (r_cnt < r_on_limit) r_col_drive <= r_shadow[r_row];
            if (r_cnt == CW'(ROW_CYCLES - 1)) begin
              r_cnt <= '0;
              if (r_row == 4'(ROWS - 1)) begin
                r_row   <= '0;
                r_state <= S_LOAD;
              end else begin
                r_row   <= r_row + 4'd1;
                r_state <= S_BLANK;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.row_sel     = r_row_sel;
  assign bus.col_drive   = r_col_drive;
  assign bus.frame_start = r_frame_start;
  assign bus.row_idx     = r_row_idx;
endmodule

// File: tb/tb_led_row_scanner.sv
// Random-stimulus bench for led_row_scanner against a frame-phase reference model.
module tb_led_row_scanner;
  localparam int ROWS = 10, COLS = 10, RC = 16, BC = 2;
  localparam int P  = BC + RC;
  localparam int FP = 1 + ROWS * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_row_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  led_row_scanner #(.ROWS(ROWS), .COLS(COLS), .ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int fs_times[$];
  int on_cnt[ROWS], dr_cnt[ROWS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference: position m_p within the frame (0 = load slot), decoded arithmetically.
  bit               m_idle = 1'b1;
  int               m_p = 0;
  int               m_onl = 0;
  logic [COLS-1:0]  m_sh[ROWS];
  logic [ROWS-1:0]  e_rs;
  logic [COLS-1:0]  e_cd;
  logic             e_fs;
  int               e_row;

  task automatic model();
    e_rs = '0; e_cd = '0; e_fs = 1'b0;
    e_row = (m_idle || m_p == 0) ? 0 : (m_p - 1) / P;
    if (!bus.enable) m_idle = 1'b1;
    else if (m_idle) begin
      m_idle = 1'b0;
      m_p = 0;
    end else if (m_p == 0) begin
      e_fs = 1'b1;
      for (int r = 0; r < ROWS; r++) m_sh[r] = bus.frame_in[COLS*r +: COLS];
      m_onl = ((int'(bus.brightness) + 1) * RC) / 16;
      m_p = 1;
    end else begin
      int q, r, k;
      q = m_p - 1; r = q / P; k = q % P;
      if (k >= BC) begin
        e_rs = ROWS'(1) << r;
        if (k - BC < m_onl) e_cd = m_sh[r];
      end
      m_p = (m_p == ROWS * P) ? 0 : m_p + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    cyc++;
    chk("row_sel", 32'(bus.row_sel), 32'(e_rs));
    chk("col_drive", 32'(bus.col_drive), 32'(e_cd));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("row_idx", 32'(bus.row_idx), 32'(e_row));
    if (bus.frame_start) fs_times.push_back(cyc);
    for (int r = 0; r < ROWS; r++)
      if (bus.row_sel[r]) begin
        on_cnt[r]++;
        if (bus.col_drive != '0) dr_cnt[r]++;
      end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FP && !seen; i++) begin
      step();
      seen = bus.frame_start;
    end
    if (!seen) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_frame(input bit nonzero);
    for (int r = 0; r < ROWS; r++)
      bus.frame_in[COLS*r +: COLS] = COLS'($urandom) | (nonzero ? COLS'(1) : COLS'(0));
  endtask

  task automatic duty_test(input logic [3:0] bri, input int want);
    bus.brightness = bri;
    rand_frame(1'b1);
    wait_fs();
    for (int r = 0; r < ROWS; r++) begin on_cnt[r] = 0; dr_cnt[r] = 0; end
    run(FP - 1);
    for (int r = 0; r < ROWS; r++) begin
      chk("duty_sel", 32'(on_cnt[r]), 32'(RC));
      chk("duty_on", 32'(dr_cnt[r]), 32'(want));
    end
  endtask

  task automatic until_row(input int row, input int dwell);
    int hits = 0;
    for (int i = 0; i < 3 * FP && hits < dwell; i++) begin
      step();
      if (bus.row_sel == ROWS'(1) << row) hits++;
    end
    if (hits < dwell) chk("row_timeout", 32'(hits), 32'(dwell));
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.brightness = 4'd15;
    bus.frame_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_sel", 32'(bus.row_sel), 32'd0);
    chk("rst_col_drive", 32'(bus.col_drive), 32'd0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    chk("rst_row_idx", 32'(bus.row_idx), 32'd0);

    // Fixed pattern, full brightness; check frame period.
    for (int r = 0; r < ROWS; r++) bus.frame_in[COLS*r +: COLS] = 10'b0110000110;
    bus.enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(2 * FP + 5);
    chk("fs_count", 32'(fs_times.size() >= 2), 32'd1);
    if (fs_times.size() >= 2) chk("fs_period", 32'(fs_times[1] - fs_times[0]), 32'(FP));

    // Distinct rows.
    for (int r = 0; r < ROWS; r++) bus.frame_in[COLS*r +: COLS] = COLS'(1) << r;
    bus.brightness = 4'($urandom);
    wait_fs();
    run(FP);

    duty_test(4'd0, 1);
    duty_test(4'd7, 8);

    // Mid-frame change during row 4 takes effect only at the next load.
    rand_frame(1'b0);
    bus.brightness = 4'($urandom);
    wait_fs();
    until_row(4, 5);
    rand_frame(1'b0);
    bus.brightness = 4'($urandom);
    wait_fs();
    run(FP);

    // Disable mid-drive on row 6.
    until_row(6, 4);
    bus.enable = 1'b0;
    step();
    chk("dis_row_sel", 32'(bus.row_sel), 32'd0);
    chk("dis_col_drive", 32'(bus.col_drive), 32'd0);
    run(6);
    chk("dis_hold", 32'(bus.row_sel | bus.col_drive), 32'd0);
    bus.enable = 1'b1;
    wait_fs();
    run(FP);

    // Asynchronous reset mid-drive.
    until_row(3, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_row_sel", 32'(bus.row_sel), 32'd0);
    chk("arst_col_drive", 32'(bus.col_drive), 32'd0);
    chk("arst_row_idx", 32'(bus.row_idx), 32'd0);
    m_idle = 1'b1;
    m_p = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_fs();
    run(FP);

    // Random soak: occasional enable toggles and input changes.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(49) == 0) begin
        rand_frame(1'b0);
        bus.brightness = 4'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
